// File: rtl/lcd_feeder_pkg.sv
// Shared types and constants for the LCD character feeder.
// Row base addresses are derived from ROW_STRIDE; rows are 0 or 1.
package lcd_feeder_pkg;

    typedef enum logic [2:0] {
        BOOT,
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    localparam logic [7:0] CMD_CLEAR  = 8'h01;
    localparam logic [7:0] CMD_DDRAM  = 8'h80;
    localparam logic [7:0] ROW_STRIDE = 8'h40;
    localparam logic [7:0] CH_NL      = 8'h0A;
    localparam logic [7:0] CH_FF      = 8'h0C;

    function automatic logic [7:0] row_base(input logic row);
        return row ? ROW_STRIDE : 8'h00;
    endfunction

endpackage

// File: rtl/lcd_char_fifo.sv
// Synchronous first-word-fall-through FIFO for the character stream.
// A push into a full FIFO is taken only when a pop frees the slot in the same cycle.
module lcd_char_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/lcd_char_feeder.sv
// Character-stream front end for an HD44780-style controller: FIFO, cursor
// tracking, character decode and busy-paced single-cycle transaction strobes.
//
// state     | meaning
// BOOT      | waiting for controller init (busy 1->0, or BOOT_IDLE quiet cycles)
// IDLE      | issue pending address, else pop and decode one character
// ISSUE     | lcd_enable high for one cycle, lcd_bus stable
// WAIT_ACK  | waiting up to ACK_TIMEOUT cycles for lcd_busy to rise
// WAIT_DONE | waiting for lcd_busy to fall
module lcd_char_feeder
    import lcd_feeder_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int COLS        = 16,
    parameter int ROWS        = 2,
    parameter int ACK_TIMEOUT = 4,
    parameter int BOOT_IDLE   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] char_data,
    input  logic       char_valid,
    output logic       char_ready,
    input  logic       lcd_busy,
    output logic       lcd_enable,
    output logic [9:0] lcd_bus,
    output logic       cursor_row,
    output logic [3:0] cursor_col,
    output logic       idle,
    output logic       ack_err
);

    localparam int TMAX = (BOOT_IDLE > ACK_TIMEOUT) ? BOOT_IDLE : ACK_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam logic [3:0] COL_LAST = 4'(COLS - 1);

    state_t        state;
    logic [TW-1:0] tmr;
    logic          busy_seen;
    logic          pend_addr;
    logic          push;
    logic          pop;
    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [AW:0]   fifo_count;

    function automatic logic next_row(input logic r);
        return (ROWS == 2) ? ~r : 1'b0;
    endfunction

    assign char_ready = !fifo_full;
    assign push       = char_valid && char_ready;
    assign pop        = (state == IDLE) && !pend_addr && !fifo_empty;

    lcd_char_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (char_data),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BOOT;
            tmr        <= TW'(BOOT_IDLE - 1);
            busy_seen  <= 1'b0;
            pend_addr  <= 1'b0;
            lcd_enable <= 1'b0;
            lcd_bus    <= '0;
            cursor_row <= 1'b0;
            cursor_col <= '0;
            idle       <= 1'b0;
            ack_err    <= 1'b0;
        end else begin
            idle <= (state == IDLE) && (fifo_count == '0);
            case (state)
                BOOT: begin
                    if (lcd_busy) begin
                        busy_seen <= 1'b1;
                        tmr       <= TW'(BOOT_IDLE - 1);
                    end else if (busy_seen || tmr == '0) begin
                        state <= IDLE;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                IDLE: begin
                    if (pend_addr) begin
                        pend_addr  <= 1'b0;
                        lcd_bus    <= {2'b00, CMD_DDRAM | row_base(cursor_row)};
                        lcd_enable <= 1'b1;
                        state      <= ISSUE;
                    end else if (!fifo_empty) begin
                        if (fifo_dout == CH_FF) begin
                            lcd_bus    <= {2'b00, CMD_CLEAR};
                            cursor_row <= 1'b0;
                            cursor_col <= '0;
                            lcd_enable <= 1'b1;
                            state      <= ISSUE;
                        end else if (fifo_dout == CH_NL) begin
                            lcd_bus    <= {2'b00, CMD_DDRAM | row_base(next_row(cursor_row))};
                            cursor_row <= next_row(cursor_row);
                            cursor_col <= '0;
                            lcd_enable <= 1'b1;
                            state      <= ISSUE;
                        end else if (fifo_dout >= 8'h20 && fifo_dout <= 8'h7E) begin
                            lcd_bus    <= {2'b10, fifo_dout};
                            lcd_enable <= 1'b1;
                            state      <= ISSUE;
                            // Wrapping defers the address command to the next IDLE visit.
                            if (cursor_col == COL_LAST) begin
                                cursor_col <= '0;
                                cursor_row <= next_row(cursor_row);
                                pend_addr  <= 1'b1;
                            end else begin
                                cursor_col <= cursor_col + 4'd1;
                            end
                        end
                    end
                end
                ISSUE: begin
                    lcd_enable <= 1'b0;
                    tmr        <= TW'(ACK_TIMEOUT - 1);
                    state      <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (lcd_busy) begin
                        state <= WAIT_DONE;
                    end else if (tmr == '0) begin
                        ack_err <= 1'b1;
                        lcd_bus <= '0;
                        state   <= IDLE;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!lcd_busy) begin
                        lcd_bus <= '0;
                        state   <= IDLE;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_char_feeder.sv
// Bench for lcd_char_feeder: table vectors, hand-written corner sequences and
// random character streams compared against a cursor/transaction model.
module tb_lcd_char_feeder;

    localparam int FIFO_DEPTH  = 8;
    localparam int COLS        = 16;
    localparam int ROWS        = 2;
    localparam int ACK_TIMEOUT = 4;
    localparam int BOOT_IDLE   = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] char_data = 8'h00;
    logic       char_valid = 1'b0;
    logic       char_ready;
    logic       lcd_busy;
    logic       lcd_enable;
    logic [9:0] lcd_bus;
    logic       cursor_row;
    logic [3:0] cursor_col;
    logic       idle;
    logic       ack_err;

    // 0: bench drives busy by hand, 1: model controller, 2: controller that never answers
    int   ctrl_mode = 0;
    logic man_busy = 1'b0;
    logic mdl_busy = 1'b0;
    int   busy_len = 50;
    int   busy_cnt = 0;
    int   dbl_pulse = 0;
    logic prev_en = 1'b0;

    logic [9:0] seen_q[$];
    logic [9:0] exp_q[$];
    int mrow = 0;
    int mcol = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] ch;
        int         pulses;
        logic [9:0] bus;
        logic       row;
        logic [3:0] col;
    } vec_t;
    vec_t vecs[9];

    assign lcd_busy = (ctrl_mode == 1) ? mdl_busy : man_busy;

    always #5 clk = ~clk;

    lcd_char_feeder #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .COLS        (COLS),
        .ROWS        (ROWS),
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .BOOT_IDLE   (BOOT_IDLE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .char_data  (char_data),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .lcd_busy   (lcd_busy),
        .lcd_enable (lcd_enable),
        .lcd_bus    (lcd_bus),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .idle       (idle),
        .ack_err    (ack_err)
    );

    initial begin : controller
        forever begin
            @(negedge clk);
            if (lcd_enable) seen_q.push_back(lcd_bus);
            if (lcd_enable && prev_en) dbl_pulse++;
            prev_en = lcd_enable;
            if (ctrl_mode == 1) begin
                if (busy_cnt > 0) begin
                    busy_cnt--;
                    if (busy_cnt == 0) mdl_busy = 1'b0;
                end else if (lcd_enable) begin
                    mdl_busy = 1'b1;
                    busy_cnt = busy_len;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // What the display should receive, from the cursor rules alone.
    task automatic model_char(input logic [7:0] c);
        int a;
        if (c == 8'h0C) begin
            exp_q.push_back(10'h001);
            mrow = 0;
            mcol = 0;
        end else if (c == 8'h0A) begin
            mrow = (mrow + 1) % ROWS;
            mcol = 0;
            a = 128 + mrow * 64;
            exp_q.push_back(a[9:0]);
        end else if (c >= 8'h20 && c <= 8'h7E) begin
            exp_q.push_back({2'b10, c});
            mcol++;
            if (mcol == COLS) begin
                mcol = 0;
                mrow = (mrow + 1) % ROWS;
                a = 128 + mrow * 64;
                exp_q.push_back(a[9:0]);
            end
        end
    endtask

    task automatic push_char(input logic [7:0] c, output bit waited);
        int n;
        n = 0;
        waited = 1'b0;
        @(negedge clk);
        char_data  = c;
        char_valid = 1'b1;
        while (!char_ready && n < 5000) begin
            waited = 1'b1;
            @(negedge clk);
            n++;
        end
        if (!char_ready) begin
            errors++;
            checks++;
            $display("FAIL push_timeout: char_ready=0 after %0d cycles, required 1", n);
            char_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            char_valid = 1'b0;
            model_char(c);
        end
    endtask

    task automatic push(input logic [7:0] c);
        bit w;
        push_char(c, w);
    endtask

    task automatic wait_quiet();
        int stable;
        int n;
        stable = 0;
        n = 0;
        while (stable < 3 && n < 20000) begin
            @(negedge clk);
            n++;
            if (idle && !lcd_busy && busy_cnt == 0) stable++;
            else stable = 0;
        end
        if (stable < 3) begin
            errors++;
            checks++;
            $display("FAIL quiet_timeout: idle not reached in %0d cycles", n);
        end
    endtask

    task automatic check_stream(input string name);
        check({name, "_count"}, seen_q.size(), exp_q.size());
        while (seen_q.size() > 0 && exp_q.size() > 0)
            check({name, "_bus"}, seen_q.pop_front(), exp_q.pop_front());
        seen_q.delete();
        exp_q.delete();
        check({name, "_row"}, cursor_row, mrow);
        check({name, "_col"}, cursor_col, mcol);
    endtask

    task automatic reset_model();
        seen_q.delete();
        exp_q.delete();
        mrow = 0;
        mcol = 0;
    endtask

    initial begin : main
        int  n;
        int  first_stall;
        bit  w;
        logic [7:0] c;

        vecs[0] = '{8'h41, 1, 10'h241, 1'b0, 4'd1};
        vecs[1] = '{8'h0A, 1, 10'h0C0, 1'b1, 4'd0};
        vecs[2] = '{8'h0C, 1, 10'h001, 1'b0, 4'd0};
        vecs[3] = '{8'h07, 0, 10'h000, 1'b0, 4'd0};
        vecs[4] = '{8'h7E, 1, 10'h27E, 1'b0, 4'd1};
        vecs[5] = '{8'h7F, 0, 10'h000, 1'b0, 4'd1};
        vecs[6] = '{8'h20, 1, 10'h220, 1'b0, 4'd2};
        vecs[7] = '{8'h1F, 0, 10'h000, 1'b0, 4'd2};
        vecs[8] = '{8'h0C, 1, 10'h001, 1'b0, 4'd0};

        // Reset values, then BOOT held by a busy controller
        ctrl_mode = 0;
        man_busy  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_enable", lcd_enable, 0);
        check("rst_bus", lcd_bus, 0);
        check("rst_row", cursor_row, 0);
        check("rst_col", cursor_col, 0);
        check("rst_ack_err", ack_err, 0);
        check("rst_idle", idle, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", char_ready, 1);
        push(8'h41);
        repeat (18) @(negedge clk);
        check("boot_no_enable", seen_q.size(), 0);
        check("boot_idle_low", idle, 0);
        man_busy  = 1'b0;
        ctrl_mode = 1;
        busy_len  = 50;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!lcd_enable && n < 20);
        check("boot_fall_to_enable", n, 2);
        wait_quiet();
        check_stream("boot_first");

        // Already-initialised controller: busy stays low
        ctrl_mode = 0;
        man_busy  = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        reset_model();
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!idle && n < 60);
        check("boot_quiet_exit", n, BOOT_IDLE + 1);
        ctrl_mode = 1;

        foreach (vecs[i]) begin
            busy_len = (i == 0) ? 50 : 6;
            push(vecs[i].ch);
            wait_quiet();
            check($sformatf("vec%0d_pulses", i), seen_q.size(), vecs[i].pulses);
            if (vecs[i].pulses > 0)
                check($sformatf("vec%0d_bus", i), seen_q[$], vecs[i].bus);
            check($sformatf("vec%0d_row", i), cursor_row, vecs[i].row);
            check($sformatf("vec%0d_col", i), cursor_col, vecs[i].col);
            check_stream($sformatf("vec%0d_model", i));
        end

        // Row wrap, both directions
        busy_len = 3;
        repeat (COLS) push(8'h30);
        wait_quiet();
        check("wrap0_pulses", seen_q.size(), COLS + 1);
        check("wrap0_addr", seen_q[$], 10'h0C0);
        check_stream("wrap0");
        check("wrap0_cursor", {cursor_row, cursor_col}, 5'h10);
        repeat (COLS) push(8'h30);
        wait_quiet();
        check("wrap1_addr", seen_q[$], 10'h080);
        check_stream("wrap1");
        check("wrap1_cursor", {cursor_row, cursor_col}, 5'h00);

        // Burst behind a long busy: one in flight plus a full FIFO before stalling
        busy_len = 50;
        first_stall = -1;
        for (int i = 0; i < 12; i++) begin
            push_char(8'h61 + 8'(i), w);
            if (w && first_stall < 0) first_stall = i;
        end
        check("burst_stall_at", first_stall, FIFO_DEPTH + 1);
        wait_quiet();
        check_stream("burst");

        // Controller never answers
        ctrl_mode = 2;
        push(8'h43);
        n = 0;
        while (!lcd_enable && n < 50) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!ack_err && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ack_timeout_cycles", n, ACK_TIMEOUT + 1);
        push(8'h44);
        wait_quiet();
        check("ack_err_sticky", ack_err, 1);
        check_stream("ack_timeout");

        // Asynchronous reset while waiting for busy to fall
        ctrl_mode = 1;
        busy_len  = 50;
        push(8'h45);
        n = 0;
        while (!lcd_busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("wait_done_bus_hold", lcd_bus, 10'h245);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_enable", lcd_enable, 0);
        check("async_bus", lcd_bus, 0);
        check("async_cursor", {cursor_row, cursor_col}, 0);
        check("async_ack_err", ack_err, 0);
        check("async_idle", idle, 0);
        reset_model();
        @(negedge clk);
        rst_n = 1'b1;

        // Random streams across varying controller busy times
        for (int k = 0; k < 80; k++) begin
            if (k % 10 == 0) busy_len = $urandom_range(1, 8);
            case ($urandom_range(0, 9))
                0: c = 8'h0A;
                1: c = 8'h0C;
                2: c = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 31)) : 8'($urandom_range(127, 255));
                default: c = 8'($urandom_range(32, 126));
            endcase
            repeat ($urandom_range(0, 2)) @(negedge clk);
            push(c);
        end
        wait_quiet();
        check_stream("random");
        check("single_cycle_enable", dbl_pulse, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
